poliriscv_imem_loader: RTL and testbench
========================================

Name: poliriscv_imem_loader

Overview:
Boot-time program writer for the single-cycle core's instruction memory.
- Accepts a byte stream: a length header, little-endian instruction words, then an XOR checksum.
- Assembles each group of 4 bytes into a 32-bit word and writes it through the imem write port at consecutive word addresses.
- Holds the core in reset for the whole load and releases it only after a valid checksum.
- Sits between the host byte source (UART RX or bench) and poliriscv_sc's instruction memory write port and reset input.

Parameters:
- INSTRUCTIONS, 256, imem depth in 32-bit words; the largest legal length header.
- ADDR_W, 8, width of the word address; must satisfy 2**ADDR_W >= INSTRUCTIONS.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers only when in_valid and in_ready are both 1 at a rising edge.
- reload  in  1  single-cycle pulse; restarts a load, honoured only in RUN or ERR.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  reset to the core; 1 for the entire load.
- done  out  1  load complete; core running.
- error  out  1  load rejected.

Behaviour:
- Reset values: state=LEN0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, byte counter=0, word counter=0, checksum accumulator=0.
- rst has priority over every other input and fully aborts a load in progress; a partially assembled word is discarded.
- States: LEN0, LEN1, DATA, CSUM, RUN, ERR.
- in_ready=1 in LEN0/LEN1/DATA/CSUM; in_ready=0 in RUN/ERR.
- Every accepted byte except the checksum byte is XORed into the accumulator.
- LEN0: accepted byte becomes len[7:0]; go to LEN1.
- LEN1: accepted byte becomes len[15:8].
  - len > INSTRUCTIONS: go to ERR.
  - len == 0: go to CSUM.
  - otherwise: go to DATA.
- DATA:
  - Bytes are placed little-endian: byte k of a word lands in bits [8k+7:8k].
  - On acceptance of the 4th byte of a word, the next cycle has imem_we=1 for exactly one cycle, imem_wdata=assembled word, imem_addr=word index (first word at 0).
  - imem_addr is held after the strobe; imem_we returns to 0.
  - After word len-1 is written, go to CSUM.
- CSUM: accepted byte is compared with the accumulator.
  - Equal: go to RUN.
  - Not equal: go to ERR.
- RUN: cpu_rst=0 and done=1, both starting the cycle after the checksum byte is accepted.
- ERR: error=1 and cpu_rst stays 1; stays in ERR until rst or reload.
- reload in RUN or ERR: next cycle state=LEN0, cpu_rst=1, done=0, error=0, counters and accumulator cleared; imem contents are not erased.
- reload in any other state: ignored.
- Gaps on in_valid (any number of idle cycles between bytes) do not change the result.
- No timeout; a stalled stream holds the current state indefinitely.
- Word counter is 16 bits, so len up to 65535 compares correctly against INSTRUCTIONS.

Test Plan:
- Two-word load: bytes 02 00 93 00 50 00 13 01 A0 00 73 -> strobe addr 0 data 0x00500093, then addr 1 data 0x00A00113; cpu_rst 1->0 and done=1 the cycle after byte 0x73; error=0; in_ready=0 afterwards.
- Empty program: bytes 00 00 00 -> no imem_we; done=1, cpu_rst=0.
- Oversize header: bytes 01 01 (len=257) -> error=1 the cycle after the second byte; in_ready=0; no writes; cpu_rst=1.
- Bad checksum: two-word stream with final byte 0x72 -> both writes occur; then error=1, done=0, cpu_rst=1; a reload pulse returns in_ready=1 and error=0.
- Stalled stream: two-word load with in_valid low for 3 cycles between every byte -> same writes and final state as the two-word load test.
- Reset mid-load: assert rst for 1 cycle after the 5th byte -> all outputs at reset values; a fresh 00 00 00 stream then completes with done=1.

Source files
------------

// File: rtl/poliriscv_imem_loader.sv
// Boot loader: takes a length-prefixed, XOR-checksummed byte stream, writes little-endian
// words into instruction memory, and holds the core in reset until the checksum matches.
module poliriscv_imem_loader #(
    parameter int INSTRUCTIONS = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

    localparam logic [16:0] MAX_LEN = 17'(INSTRUCTIONS);

    state_t              r_state, w_next;
    logic [15:0]         r_len;
    logic [1:0]          r_byte_cnt;
    logic [15:0]         r_word_cnt;
    logic [7:0]          r_acc;
    logic [23:0]         r_word;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic                w_fire;
    logic [15:0]         w_len_full;
    logic                w_last_word;
    logic                w_reload_ok;

    assign in_ready    = (r_state != RUN) && (r_state != ERR);
    assign w_fire      = in_valid && in_ready;
    assign w_len_full  = {in_data, r_len[7:0]};
    assign w_last_word = (r_byte_cnt == 2'd3) && (r_word_cnt == r_len - 16'd1);
    assign w_reload_ok = reload && ((r_state == RUN) || (r_state == ERR));

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = (r_state != RUN);
    assign done       = (r_state == RUN);
    assign error      = (r_state == ERR);

    always_ff @(posedge clk) begin
        if (rst) r_state <= LEN0;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LEN0: if (w_fire) w_next = LEN1;
            LEN1: if (w_fire) begin
                if ({1'b0, w_len_full} > MAX_LEN) w_next = ERR;
                else if (w_len_full == 16'd0)     w_next = CSUM;
                else                              w_next = DATA;
            end
            DATA: if (w_fire && w_last_word) w_next = CSUM;
            CSUM: if (w_fire) w_next = (in_data == r_acc) ? RUN : ERR;
            RUN, ERR: if (reload) w_next = LEN0;
            default: w_next = LEN0;
        endcase
    end

    // Byte 3 goes straight from in_data into the write word, so only 24 bits are buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_acc      <= '0;
            r_word     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_reload_ok) begin
                r_len      <= '0;
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
                r_acc      <= '0;
            end else if (w_fire) begin
                if (r_state != CSUM) r_acc <= r_acc ^ in_data;
                case (r_state)
                    LEN0: r_len[7:0]  <= in_data;
                    LEN1: r_len[15:8] <= in_data;
                    DATA: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= in_data;
                            2'd1: r_word[15:8]  <= in_data;
                            2'd2: r_word[23:16] <= in_data;
                            default: begin
                                r_we       <= 1'b1;
                                r_wdata    <= {in_data, r_word};
                                r_addr     <= r_word_cnt[ADDR_W-1:0];
                                r_word_cnt <= r_word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poliriscv_imem_loader.sv
// Directed bench for the imem loader: captures write strobes and checks final status outputs.
module tb_poliriscv_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    int          wr_cnt = 0;
    logic [7:0]  wr_addr [8];
    logic [31:0] wr_data [8];

    logic [7:0] two_word [11];

    poliriscv_imem_loader #(.INSTRUCTIONS(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_cnt = 0;
    endtask

    task automatic check_two_word_result(input string tag);
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL %s wr_cnt got %0d want 2", tag, wr_cnt); end
        checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00500093) begin
            errors++; $display("FAIL %s write0 got %0d/%h want 0/00500093", tag, wr_addr[0], wr_data[0]); end
        checks++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00A00113) begin
            errors++; $display("FAIL %s write1 got %0d/%h want 1/00a00113", tag, wr_addr[1], wr_data[1]); end
        checks++; if ({cpu_rst, done, error, in_ready} !== 4'b0100) begin
            errors++; $display("FAIL %s status cpu_rst/done/error/in_ready got %b want 0100", tag, {cpu_rst, done, error, in_ready}); end
        checks++; if (imem_addr !== 8'd1 || imem_we !== 1'b0) begin
            errors++; $display("FAIL %s addr_hold got %0d we %b want 1 we 0", tag, imem_addr, imem_we); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({in_ready, imem_we, cpu_rst, done, error} !== 5'b10100) begin
            errors++; $display("FAIL reset_flags got %b want 10100", {in_ready, imem_we, cpu_rst, done, error}); end
        checks++; if (imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_bus got %0d/%h want 0/0", imem_addr, imem_wdata); end
    endtask

    task automatic test_two_word();
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(two_word[i], 0);
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL tw_before_csum cpu_rst %b done %b want 1 0", cpu_rst, done); end
        send_byte(8'h73, 0);
        check_two_word_result("two_word");
    endtask

    task automatic test_empty();
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL empty_writes got %0d want 0", wr_cnt); end
        checks++; if ({done, cpu_rst, error} !== 3'b100) begin
            errors++; $display("FAIL empty_status done/cpu_rst/error got %b want 100", {done, cpu_rst, error}); end
    endtask

    task automatic test_oversize();
        do_reset();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        checks++; if ({error, in_ready, cpu_rst, done} !== 4'b1010) begin
            errors++; $display("FAIL oversize_status error/in_ready/cpu_rst/done got %b want 1010", {error, in_ready, cpu_rst, done}); end
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL oversize_writes got %0d want 0", wr_cnt); end
        // len == INSTRUCTIONS is the largest legal header
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL max_len error %b in_ready %b want 0 1", error, in_ready); end
    endtask

    task automatic test_bad_csum();
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(two_word[i], 0);
        send_byte(8'h72, 0);
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL badcs_writes got %0d want 2", wr_cnt); end
        checks++; if ({error, done, cpu_rst, in_ready} !== 4'b1010) begin
            errors++; $display("FAIL badcs_status error/done/cpu_rst/in_ready got %b want 1010", {error, done, cpu_rst, in_ready}); end
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        checks++; if ({in_ready, error, cpu_rst, done} !== 4'b1010) begin
            errors++; $display("FAIL reload_status in_ready/error/cpu_rst/done got %b want 1010", {in_ready, error, cpu_rst, done}); end
        // accumulator must be cleared by reload for an empty program to pass
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_empty done got %b want 1", done); end
    endtask

    task automatic test_stalled();
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(two_word[i], 3);
        send_byte(8'h73, 3);
        check_two_word_result("stalled");
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(two_word[i], 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({in_ready, imem_we, cpu_rst, done, error} !== 5'b10100 || imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
            errors++; $display("FAIL midrst_outputs got %b %0d %h want 10100 0 0", {in_ready, imem_we, cpu_rst, done, error}, imem_addr, imem_wdata); end
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++; if ({done, cpu_rst, error} !== 3'b100 || wr_cnt !== 0) begin
            errors++; $display("FAIL midrst_reload got %b writes %0d want 100 0", {done, cpu_rst, error}, wr_cnt); end
    endtask

    initial begin
        two_word = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        test_reset();
        test_two_word();
        test_empty();
        test_oversize();
        test_bad_csum();
        test_stalled();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
